// File: rtl/text_normalizer.sv
// ---------------------------------------------------------------------------
// text_normalizer
//   Converts a raw ASCII byte stream into the word-checker alphabet. Letters
//   are optionally lowercased. Each run of separators (whitespace and
//   , . ; :) becomes a single 0x20. Non-printable bytes are dropped and
//   counted. A 0x00 byte marks end of stream and emits a flagged
//   terminating space. Results are queued in a small FIFO for the consumer.
//
// Ports
//   clk        rising-edge clock
//   reset      asynchronous, active-high reset
//   in_data    raw input byte
//   in_valid   in_data is valid
//   in_ready   stage can accept a byte (FIFO not full)
//   out_data   normalized byte at the FIFO head (0 when empty)
//   out_valid  out_data is valid
//   out_ready  consumer takes out_data this cycle
//   out_last   head byte is the end-of-stream space
//   drop_cnt   saturating count of dropped bytes
// ---------------------------------------------------------------------------
module text_normalizer #(
    parameter int DEPTH     = 2,
    parameter bit LOWERCASE = 1'b1,
    parameter int CNT_W     = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [7:0]       in_data,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [7:0]       out_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             out_last,
    output logic [CNT_W-1:0] drop_cnt
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0]      PTR_ONE = 1;
    localparam logic [CNT_W-1:0] CNT_ONE = 1;

    typedef enum logic {
        ST_SEP  = 1'b0,
        ST_WORD = 1'b1
    } state_t;

    state_t           r_state;
    state_t           w_state_nxt;
    logic [AW:0]      r_wr_ptr;
    logic [AW:0]      r_rd_ptr;
    logic [8:0]       r_mem [DEPTH];
    logic [CNT_W-1:0] r_drop_cnt;

    logic       w_full;
    logic       w_empty;
    logic       w_accept;
    logic       w_pop;
    logic       w_is_eos;
    logic       w_is_sep;
    logic       w_is_drop;
    logic       w_push;
    logic [7:0] w_push_data;
    logic       w_push_last;
    logic       w_drop;
    logic [8:0] w_head;

    // Full/empty come from registered pointers only, so in_ready never
    // depends combinationally on out_ready.
    assign w_full   = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                      (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
    assign w_empty  = (r_wr_ptr == r_rd_ptr);
    assign w_accept = in_valid & ~w_full;
    assign w_pop    = ~w_empty & out_ready;

    assign w_is_eos  = (in_data == 8'h00);
    assign w_is_sep  = (in_data == 8'h20) || (in_data == 8'h09) ||
                       (in_data == 8'h0A) || (in_data == 8'h0D) ||
                       (in_data == 8'h2C) || (in_data == 8'h2E) ||
                       (in_data == 8'h3B) || (in_data == 8'h3A);
    // Tabs, LF and CR are below 0x20 but are separators, not drops.
    assign w_is_drop = ~w_is_eos && ~w_is_sep &&
                       ((in_data < 8'h20) || (in_data >= 8'h7F));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= ST_SEP;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_push      = 1'b0;
        w_push_data = in_data;
        w_push_last = 1'b0;
        w_drop      = 1'b0;
        if (w_accept) begin
            if (w_is_eos) begin
                w_push      = 1'b1;
                w_push_data = 8'h20;
                w_push_last = 1'b1;
                w_state_nxt = ST_SEP;
            end else if (w_is_drop) begin
                w_drop = 1'b1;
            end else if (w_is_sep) begin
                // Only the first separator after a word produces a space.
                w_push      = (r_state == ST_WORD);
                w_push_data = 8'h20;
                w_state_nxt = ST_SEP;
            end else begin
                w_push = 1'b1;
                if (LOWERCASE && (in_data >= 8'h41) && (in_data <= 8'h5A)) begin
                    w_push_data = in_data + 8'h20;
                end
                w_state_nxt = ST_WORD;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_drop_cnt <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + PTR_ONE;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_ONE;
            end
            if (w_drop && (r_drop_cnt != {CNT_W{1'b1}})) begin
                r_drop_cnt <= r_drop_cnt + CNT_ONE;
            end
        end
    end

    // Storage carries no reset; validity is tracked by the pointers alone.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr[AW-1:0]] <= {w_push_last, w_push_data};
        end
    end

    assign w_head    = r_mem[r_rd_ptr[AW-1:0]];
    assign in_ready  = ~w_full;
    assign out_valid = ~w_empty;
    assign out_data  = w_empty ? 8'h00 : w_head[7:0];
    assign out_last  = w_empty ? 1'b0  : w_head[8];
    assign drop_cnt  = r_drop_cnt;

endmodule

// File: tb/tb_text_normalizer.sv
module tb_text_normalizer;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset;
    logic [7:0]  a_id, b_id;
    logic        a_iv, b_iv, a_ir, b_ir;
    logic [7:0]  a_od, b_od;
    logic        a_ov, b_ov, a_or, b_or, a_ol, b_ol;
    logic [15:0] a_dc;
    logic [1:0]  b_dc;

    int n_chk  = 0;
    int n_pass = 0;

    // Reference model state per DUT: expected FIFO contents {last,data},
    // "inside a word" flag and drop count.
    logic [8:0] q [2][$];
    bit         in_word [2];
    int         drops [2];

    int ready_mode = 0;
    int cyc = 0;

    text_normalizer #(.DEPTH(2), .LOWERCASE(1'b1), .CNT_W(16)) u_dut_a (
        .clk(clk), .reset(reset),
        .in_data(a_id), .in_valid(a_iv), .in_ready(a_ir),
        .out_data(a_od), .out_valid(a_ov), .out_ready(a_or),
        .out_last(a_ol), .drop_cnt(a_dc)
    );

    text_normalizer #(.DEPTH(4), .LOWERCASE(1'b0), .CNT_W(2)) u_dut_b (
        .clk(clk), .reset(reset),
        .in_data(b_id), .in_valid(b_iv), .in_ready(b_ir),
        .out_data(b_od), .out_valid(b_ov), .out_ready(b_or),
        .out_last(b_ol), .drop_cnt(b_dc)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    endtask

    // Compare one DUT's outputs against the model, then advance the model
    // with whatever transfers happen at the coming rising edge.
    task automatic mon(input int k, input logic ov, input logic ir, input logic [7:0] od,
                       input logic ol, input logic [31:0] dc, input logic ordy,
                       input logic iv, input logic [7:0] id, input int depth,
                       input bit lc, input int maxd);
        chk(k == 0 ? "a_out_valid" : "b_out_valid", {31'd0, ov}, {31'd0, q[k].size() != 0});
        chk(k == 0 ? "a_in_ready" : "b_in_ready", {31'd0, ir}, {31'd0, q[k].size() < depth});
        chk(k == 0 ? "a_drop_cnt" : "b_drop_cnt", dc, drops[k]);
        if (q[k].size() != 0) chk(k == 0 ? "a_head" : "b_head", {23'd0, ol, od}, {23'd0, q[k][0]});
        else                  chk(k == 0 ? "a_idle_out" : "b_idle_out", {23'd0, ol, od}, 32'd0);
        if (ov && ordy && q[k].size() != 0) void'(q[k].pop_front());
        if (iv && ir) begin
            if (id == 8'h00) begin
                q[k].push_back({1'b1, 8'h20});
                in_word[k] = 1'b0;
            end else if (id inside {8'h20, 8'h09, 8'h0A, 8'h0D, ",", ".", ";", ":"}) begin
                if (in_word[k]) q[k].push_back({1'b0, 8'h20});
                in_word[k] = 1'b0;
            end else if (id < 8'h20 || id >= 8'h7F) begin
                if (drops[k] < maxd) drops[k]++;
            end else begin
                if (lc && id inside {["A":"Z"]}) q[k].push_back({1'b0, id + 8'h20});
                else                             q[k].push_back({1'b0, id});
                in_word[k] = 1'b1;
            end
        end
    endtask

    always @(negedge clk) begin
        if (reset) begin
            for (int k = 0; k < 2; k++) begin
                q[k].delete();
                in_word[k] = 1'b0;
                drops[k]   = 0;
            end
        end else begin
            mon(0, a_ov, a_ir, a_od, a_ol, {16'd0, a_dc}, a_or, a_iv, a_id, 2, 1'b1, 65535);
            mon(1, b_ov, b_ir, b_od, b_ol, {30'd0, b_dc}, b_or, b_iv, b_id, 4, 1'b0, 3);
        end
    end

    always @(posedge clk) begin
        logic [4:0] pat;
        #1;
        cyc++;
        pat = 5'b01101;  // 1,0,1,1,0 read from bit 0 upward
        case (ready_mode)
            0:       a_or = 1'b1;
            1:       a_or = 1'($urandom_range(0, 1));
            2:       a_or = 1'b0;
            default: a_or = pat[cyc % 5];
        endcase
        b_or = 1'b1;
    end

    // Called just after a rising edge; holds the byte until it is accepted.
    task automatic send(input int k, input logic [7:0] b);
        bit acc;
        int n;
        n = 0;
        if (k == 0) begin a_id = b; a_iv = 1'b1; end
        else        begin b_id = b; b_iv = 1'b1; end
        do begin
            acc = (k == 0) ? a_ir : b_ir;
            @(posedge clk); #1;
            n++;
        end while (!acc && n < 200);
        if (!acc) chk("send_accept", {31'd0, acc}, 32'd1);
    endtask

    task automatic send_str(input int k, input string s);
        for (int i = 0; i < s.len(); i++) send(k, s[i]);
    endtask

    task automatic idle();
        a_iv = 1'b0;
        b_iv = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        idle();
        while ((q[0].size() != 0 || q[1].size() != 0) && n < 500) begin
            @(posedge clk); #1;
            n++;
        end
        chk("drain_empty", q[0].size() + q[1].size(), 0);
        @(posedge clk); #1;
    endtask

    initial begin
        logic [7:0] seps [8];
        logic [7:0] r;
        seps = '{8'h20, 8'h09, 8'h0A, 8'h0D, ",", ".", ";", ":"};
        reset = 1'b1;
        a_id = 8'h00; b_id = 8'h00; a_iv = 1'b0; b_iv = 1'b0;
        a_or = 1'b1;  b_or = 1'b1;

        repeat (2) @(posedge clk);
        #1;
        chk("rst_out_valid", {31'd0, a_ov}, 32'd0);
        chk("rst_out_data", {24'd0, a_od}, 32'd0);
        chk("rst_out_last", {31'd0, a_ol}, 32'd0);
        chk("rst_in_ready", {31'd0, a_ir}, 32'd1);
        chk("rst_drop_cnt", {16'd0, a_dc}, 32'd0);
        reset = 1'b0;
        @(posedge clk); #1;

        // Basic mapping with end of stream
        ready_mode = 0;
        send_str(0, "Begin end");
        send(0, 8'h00);
        drain();

        // Leading separators and collapse
        send(0, 8'h20); send(0, 8'h09); send(0, "A"); send(0, ",");
        send(0, 8'h0A); send(0, 8'h20); send(0, "B");
        drain();
        chk("collapse_drops", {16'd0, a_dc}, 32'd0);

        // Drops keep the word open
        send(0, "x"); send(0, 8'h01); send(0, 8'h7F); send(0, 8'hFF); send(0, "y");
        drain();
        chk("drop_cnt_3", {16'd0, a_dc}, 32'd3);

        // Backpressure on the 2-entry FIFO
        ready_mode = 2;
        repeat (2) begin @(posedge clk); #1; end
        send(0, "a"); send(0, "b");
        a_id = "c"; a_iv = 1'b1;
        repeat (3) begin @(posedge clk); #1; end
        chk("bp_in_ready", {31'd0, a_ir}, 32'd0);
        chk("bp_head_data", {24'd0, a_od}, 32'h61);
        chk("bp_head_valid", {31'd0, a_ov}, 32'd1);
        ready_mode = 0;
        send(0, "c");
        drain();

        // Simultaneous push/pop with pointer wrap
        ready_mode = 3;
        for (int i = 0; i < 20; i++) send(0, 8'(8'h41 + $urandom_range(0, 25)));
        send(0, 8'h00);
        drain();

        // Randomized mixture
        ready_mode = 1;
        for (int i = 0; i < 300; i++) begin
            if ($urandom_range(0, 3) == 0) begin
                idle();
                @(posedge clk); #1;
            end else begin
                case ($urandom_range(0, 9))
                    0, 1, 2:    r = 8'(8'h41 + $urandom_range(0, 25));
                    3, 4:       r = 8'(8'h61 + $urandom_range(0, 25));
                    5, 6:       r = seps[$urandom_range(0, 7)];
                    7:          r = 8'($urandom_range(8'h21, 8'h7E));
                    8:          r = ($urandom_range(0, 1) != 0) ? 8'($urandom_range(8'h80, 8'hFF)) : 8'h01;
                    default:    r = 8'h00;
                endcase
                send(0, r);
            end
        end
        send(0, 8'h00);
        ready_mode = 0;
        drain();

        // Asynchronous reset while two entries are queued
        ready_mode = 2;
        repeat (2) begin @(posedge clk); #1; end
        send(0, "p"); send(0, "q");
        idle();
        @(posedge clk); #3;
        reset = 1'b1;
        #1;
        chk("arst_out_valid", {31'd0, a_ov}, 32'd0);
        chk("arst_drop_cnt", {16'd0, a_dc}, 32'd0);
        chk("arst_in_ready", {31'd0, a_ir}, 32'd1);
        @(posedge clk); #3;
        reset = 1'b0;
        ready_mode = 0;
        @(posedge clk); #1;
        send(0, 8'h20);
        idle();
        repeat (3) begin
            @(posedge clk); #1;
            chk("arst_sep_suppressed", {31'd0, a_ov}, 32'd0);
        end
        send(0, "z"); send(0, 8'h00);
        drain();

        // LOWERCASE=0 and 2-bit drop counter saturation
        send_str(1, "END");
        send(1, 8'h00);
        for (int i = 0; i < 8; i++) send(1, 8'h05);
        drain();
        chk("b_drop_sat", {30'd0, b_dc}, 32'd3);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
